// File: rtl/hazard_unit.sv
// In-order pipeline hazard unit: a small shift-register scoreboard of in-flight
// writers that drives load-use stalls, redirect flushes and forwarding selects.
module hazard_unit #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 16,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_d,
  input  logic [AW-1:0] rs1_d,
  input  logic [AW-1:0] rs2_d,
  input  logic          use1_d,
  input  logic          use2_d,
  input  logic [AW-1:0] rd_d,
  input  logic          regwrite_d,
  input  logic          load_d,
  input  logic          redirect,
  output logic          stall,
  output logic          flush,
  output logic [SW-1:0] fwd1_sel,
  output logic [SW-1:0] fwd2_sel,
  output logic [CW-1:0] stall_count
);

  logic [DEPTH:1]    valid_reg;
  logic [DEPTH:1]    regwrite_reg;
  logic [AW-1:0]     rd_reg [1:DEPTH];
  // The load flag only matters while the load sits inside the unforwardable window.
  logic [LOAD_LAT:1] load_reg;

  logic [DEPTH:1]    hit1;
  logic [DEPTH:1]    hit2;
  logic [LOAD_LAT:1] load_use;
  logic              hazard;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_match
      assign hit1[gi] = valid_reg[gi] & regwrite_reg[gi] & (rd_reg[gi] != '0) &
                        use1_d & (rd_reg[gi] == rs1_d);
      assign hit2[gi] = valid_reg[gi] & regwrite_reg[gi] & (rd_reg[gi] != '0) &
                        use2_d & (rd_reg[gi] == rs2_d);
    end
    for (gi = 1; gi <= LOAD_LAT; gi++) begin : g_load_use
      assign load_use[gi] = load_reg[gi] & (hit1[gi] | hit2[gi]);
    end
  endgenerate

  assign hazard = valid_d & (|load_use);
  assign stall  = hazard & ~redirect;
  assign flush  = redirect;

  // Youngest producer wins: scan oldest to youngest so the lowest stage is assigned last.
  always_comb begin
    fwd1_sel = '0;
    fwd2_sel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit1[k]) fwd1_sel = SW'(k);
      if (hit2[k]) fwd2_sel = SW'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg    <= '0;
      regwrite_reg <= '0;
      load_reg     <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_reg[k] <= '0;
    end else begin
      valid_reg[1]    <= valid_d & ~stall & ~redirect;
      regwrite_reg[1] <= regwrite_d;
      rd_reg[1]       <= rd_d;
      load_reg[1]     <= load_d;
      for (int k = 2; k <= DEPTH; k++) begin
        valid_reg[k]    <= valid_reg[k-1];
        regwrite_reg[k] <= regwrite_reg[k-1];
        rd_reg[k]       <= rd_reg[k-1];
      end
      for (int k = 2; k <= LOAD_LAT; k++) load_reg[k] <= load_reg[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CW{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed pipeline scenarios plus random
// traffic, checked against a queue-of-history reference model.
module tb_hazard_unit;

  localparam int AW       = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int CW       = 4;
  localparam int SW       = $clog2(DEPTH + 1);
  localparam int CMAX     = (1 << CW) - 1;

  logic          clk = 1'b1;
  logic          reset = 1'b1;
  logic          valid_d = 1'b0;
  logic [AW-1:0] rs1_d = '0;
  logic [AW-1:0] rs2_d = '0;
  logic          use1_d = 1'b0;
  logic          use2_d = 1'b0;
  logic [AW-1:0] rd_d = '0;
  logic          regwrite_d = 1'b0;
  logic          load_d = 1'b0;
  logic          redirect = 1'b0;
  logic          stall;
  logic          flush;
  logic [SW-1:0] fwd1_sel;
  logic [SW-1:0] fwd2_sel;
  logic [CW-1:0] stall_count;

  hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CW(CW)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use1_d(use1_d), .use2_d(use2_d),
    .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .redirect(redirect),
    .stall(stall), .flush(flush), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit [AW-1:0] rs1;
    bit          u1;
    bit [AW-1:0] rs2;
    bit          u2;
    bit [AW-1:0] rd;
    bit          rw;
    bit          ld;
  } ins_t;

  typedef struct {
    bit          v;
    bit [AW-1:0] rd;
    bit          rw;
    bit          ld;
  } ent_t;

  typedef struct {
    int id;
    bit stall;
    bit flush;
    int f1;
    int f2;
    int cnt;
  } exp_t;

  ent_t hist[$];   // hist[0] is the instruction currently in EX (stage 1)
  exp_t exp_q[$];
  int   cnt_m = 0;
  int   txn = 0;
  int   total = 0;
  int   bad = 0;

  function automatic ins_t mk(bit v, int rd, bit rw, bit ld, int rs1, bit u1, int rs2, bit u2);
    ins_t r;
    r.v = v; r.rd = AW'(rd); r.rw = rw; r.ld = ld;
    r.rs1 = AW'(rs1); r.u1 = u1; r.rs2 = AW'(rs2); r.u2 = u2;
    return r;
  endfunction

  // Stage number of the youngest in-flight writer of rs, or 0.
  function automatic int find_src(bit [AW-1:0] rs, bit u);
    if (!u || rs == 0) return 0;
    foreach (hist[i])
      if (hist[i].v && hist[i].rw && hist[i].rd == rs) return i + 1;
    return 0;
  endfunction

  function automatic bit load_hit(bit [AW-1:0] rs, bit u);
    if (!u || rs == 0) return 0;
    foreach (hist[i])
      if (i < LOAD_LAT && hist[i].v && hist[i].rw && hist[i].ld && hist[i].rd == rs) return 1;
    return 0;
  endfunction

  function automatic bit would_stall(ins_t in);
    return in.v && (load_hit(in.rs1, in.u1) || load_hit(in.rs2, in.u2));
  endfunction

  task automatic cycle(input ins_t in, input bit redir, input bit rst, output bit st);
    exp_t e;
    ent_t n;
    reset = rst;
    valid_d = in.v; rs1_d = in.rs1; use1_d = in.u1; rs2_d = in.rs2; use2_d = in.u2;
    rd_d = in.rd; regwrite_d = in.rw; load_d = in.ld; redirect = redir;
    if (!rst) begin
      hist.delete();
      cnt_m = 0;
    end
    e.id    = txn++;
    e.stall = rst && !redir && would_stall(in);
    e.flush = redir;
    e.f1    = rst ? find_src(in.rs1, in.u1) : 0;
    e.f2    = rst ? find_src(in.rs2, in.u2) : 0;
    e.cnt   = cnt_m;
    exp_q.push_back(e);
    st = e.stall;
    @(posedge clk);
    if (rst) begin
      n.v = in.v && !e.stall && !redir;
      n.rd = in.rd; n.rw = in.rw; n.ld = in.ld;
      hist.push_front(n);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      if (e.stall && cnt_m < CMAX) cnt_m++;
    end
    #1;
  endtask

  // Present an instruction and keep it in decode for as long as it is stalled.
  task automatic issue(input ins_t in);
    bit st;
    for (int t = 0; t < 8; t++) begin
      cycle(in, 1'b0, 1'b1, st);
      if (!st) break;
    end
  endtask

  task automatic chk(string nm, int id, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s txn=%0d got=%0d want=%0d", nm, id, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %0d stall=%0d flush=%0d fwd1=%0d fwd2=%0d count=%0d",
                 e.id, stall, flush, fwd1_sel, fwd2_sel, stall_count);
        chk("stall", e.id, int'(stall), int'(e.stall));
        chk("flush", e.id, int'(flush), int'(e.flush));
        chk("fwd1_sel", e.id, int'(fwd1_sel), e.f1);
        chk("fwd2_sel", e.id, int'(fwd2_sel), e.f2);
        chk("stall_count", e.id, int'(stall_count), e.cnt);
      end
    end
  end

  initial begin : driver
    bit   st;
    ins_t bub, lw7;
    bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
    lw7 = mk(1, 7, 1, 1, 7, 1, 0, 0);
    #1;
    // Reset held low, including a redirect that must still flush.
    cycle(mk(1, 4, 1, 1, 4, 1, 4, 1), 1'b0, 1'b0, st);
    cycle(bub, 1'b1, 1'b0, st);
    cycle(bub, 1'b0, 1'b1, st);
    // Back-to-back ALU forwarding, then a later consumer.
    issue(mk(1, 5, 1, 0, 1, 1, 2, 1));
    issue(mk(1, 6, 1, 0, 5, 1, 1, 1));
    issue(mk(1, 9, 1, 0, 5, 1, 0, 0));
    // Load-use stall followed by forwarding from stage 2.
    issue(mk(1, 7, 1, 1, 1, 1, 0, 0));
    issue(mk(1, 8, 1, 0, 7, 1, 7, 1));
    // Double producer: youngest wins.
    issue(mk(1, 3, 1, 0, 1, 1, 2, 1));
    issue(mk(1, 3, 1, 0, 3, 1, 0, 0));
    issue(mk(1, 4, 1, 0, 3, 1, 3, 1));
    // x0 writer never forwards.
    issue(mk(1, 0, 1, 0, 1, 1, 0, 0));
    issue(mk(1, 2, 1, 0, 0, 1, 0, 1));
    // Load-use coincident with redirect.
    issue(mk(1, 9, 1, 1, 1, 1, 0, 0));
    cycle(mk(1, 10, 1, 0, 9, 1, 0, 0), 1'b1, 1'b1, st);
    issue(mk(1, 11, 1, 0, 9, 1, 9, 1));
    // Repeated self-dependent load: stalls every other cycle until saturation.
    for (int i = 0; i < 40; i++) cycle(lw7, 1'b0, 1'b1, st);
    for (int t = 0; t < 4 && !would_stall(lw7); t++) cycle(lw7, 1'b0, 1'b1, st);
    cycle(lw7, 1'b0, 1'b0, st);
    cycle(lw7, 1'b0, 1'b1, st);
    cycle(lw7, 1'b0, 1'b1, st);
    // Random traffic over a small register set to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      ins_t r;
      r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1));
      cycle(r, $urandom_range(0, 7) == 0, $urandom_range(0, 49) != 0, st);
    end
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter AW, default 5, register address width.
REQ-002 Parameter DEPTH, default 3, number of tracked in-flight stages after decode (stage 1 = EX … stage DEPTH = WB); legal range 2..8.
REQ-003 Parameter LOAD_LAT, default 1, load result unavailable for forwarding while the load occupies stages 1..LOAD_LAT; legal range 1..DEPTH-1.
REQ-004 Parameter CW, default 16, stall counter width.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-007 Port valid_d  input  1  decode stage holds a real instruction.
REQ-008 Port rs1_d, rs2_d  input  AW each  decode source register addresses.
REQ-009 Port use1_d, use2_d  input  1 each  decode instruction reads rs1 / rs2.
REQ-010 Port rd_d  input  AW  decode destination register.
REQ-011 Port regwrite_d  input  1  decode instruction writes rd.
REQ-012 Port load_d  input  1  decode instruction is a load.
REQ-013 Port redirect  input  1  taken branch/jump resolved in EX this cycle.
REQ-014 Port stall  output  1  hold PC and decode buffer this cycle.
REQ-015 Port flush  output  1  replace decode-buffer contents with a bubble.
REQ-016 Port fwd1_sel, fwd2_sel  output  clog2(DEPTH+1) each  0 = register file, k = forward from stage k.
REQ-017 Port stall_count  output  CW  saturating count of stall cycles.

Function
REQ-018 Unit SHALL hold DEPTH scoreboard entries, each {valid, rd, regwrite, load}.
REQ-019 Each cycle entries SHALL shift k -> k+1; entry DEPTH is discarded.
REQ-020 Entry 1 SHALL load {valid_d, rd_d, regwrite_d, load_d} when stall=0 and redirect=0; otherwise entry 1 SHALL load a bubble (valid=0).
REQ-021 Entry k SHALL match source s when valid=1, regwrite=1, rd!=0, rd==rs_s_d and use_s_d=1.
REQ-022 Load-use hazard SHALL exist when valid_d=1 and any entry k<=LOAD_LAT with load=1 matches rs1 or rs2.
REQ-023 stall SHALL equal hazard AND NOT redirect (combinational, from registered state and current inputs).
REQ-024 flush SHALL equal redirect; redirect and hazard simultaneous -> flush=1, stall=0.
REQ-025 fwd_s_sel SHALL be the lowest-index matching entry (youngest producer wins); 0 if none or rs_s_d==0.
REQ-026 Register x0 SHALL never cause a stall or forward.
REQ-027 fwd_s_sel SHALL be ignored-safe during stall but still computed identically.
REQ-028 stall_count SHALL increment by 1 on each rising edge where stall=1, saturating at 2^CW-1 (no wrap).
REQ-029 Zero added latency: outputs valid in the same cycle as decode inputs; scoreboard state lags by one edge.

Reset
REQ-030 reset low SHALL immediately clear all entry valid bits and stall_count to 0, independent of clk.
REQ-031 While reset low: stall=0, flush=redirect, fwd1_sel=fwd2_sel=0.
REQ-032 Reset released mid-stream SHALL resume with empty scoreboard; first edge after release loads entry 1 normally.

Verification
REQ-033 Back-to-back ALU: issue add x5 then sub x6,x5,x1 -> cycle 2 fwd1_sel=1, stall=0; one later consumer of x5 -> fwd1_sel=2.
REQ-034 Load-use: lw x7 then add x8,x7,x7 (LOAD_LAT=1) -> stall=1 one cycle, stall_count=1, then fwd1_sel=fwd2_sel=2.
REQ-035 Double producer: add x3 then addi x3 then use x3 -> fwd_sel=1 (youngest), not 2.
REQ-036 x0 writer: addi x0 then use x0 -> fwd_sel=0, stall=0.
REQ-037 Load-use coincident with redirect=1 -> stall=0, flush=1, entry 1 bubble, stall_count unchanged.
REQ-038 Saturation (CW=4): hold load-use hazard 20 cycles -> stall_count stops at 15; reset low asynchronously mid-stall -> count 0, stall=0 before next edge.
